bulls_cows_game_n: RTL

//  Parametrised two-player Bulls & Cows engine for the Nexys-A7 board: N-digit secrets and guesses,
//  a round limit with a draw outcome, and multi-cycle scoring of one digit per clock.

---
 rtl/bc_pkg.sv | 19 +
 rtl/bulls_cows_game_n_if.sv | 33 +++
 rtl/bc_digit_validator.sv | 21 ++
 rtl/bulls_cows_game_n.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared types and constants for the bulls and cows engine
package bc_pkg;

    typedef enum logic [3:0] {
        P1_SETUP = 4'd0,
        P2_SETUP = 4'd1,
        P1_GUESS = 4'd2,
        P2_GUESS = 4'd3,
        CHECK    = 4'd4,
        SCORE    = 4'd5,
        RESULT   = 4'd6,
        WIN      = 4'd7,
        DRAW     = 4'd8
    } state_t;

    // Never a legal digit; marks "no digit selected".
    localparam int DIGIT_NULL = 15;

endpackage

// File: rtl/bulls_cows_game_n_if.sv
// rtl/bulls_cows_game_n_if.sv - entry inputs and game status outputs of the engine
interface bulls_cows_game_n_if
    import bc_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int DIGIT_W    = 4,
    parameter int MAX_ROUNDS = 10
);
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int RW = $clog2(MAX_ROUNDS + 1);

    logic                         confirma;
    logic [N_DIGITS*DIGIT_W-1:0]  SW;
    state_t                       state_o;
    logic                         player_o;
    logic [CW-1:0]                bulls_o;
    logic [CW-1:0]                cows_o;
    logic [RW-1:0]                round_o;
    logic                         err_o;
    logic                         winner_o;
    logic [2*N_DIGITS-1:0]        led_o;

    modport master (
        output confirma, SW,
        input  state_o, player_o, bulls_o, cows_o, round_o, err_o, winner_o, led_o
    );

    modport slave (
        input  confirma, SW,
        output state_o, player_o, bulls_o, cows_o, round_o, err_o, winner_o, led_o
    );

endinterface

// File: rtl/bc_digit_validator.sv
// rtl/bc_digit_validator.sv - combinational check that all digits are distinct and in range
module bc_digit_validator #(
    parameter int N_DIGITS  = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_DIGIT = 9
) (
    input  logic [N_DIGITS*DIGIT_W-1:0] digits,
    output logic                        valid
);

    always_comb begin
        valid = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (int'(digits[i*DIGIT_W +: DIGIT_W]) > MAX_DIGIT) valid = 1'b0;
            for (int j = i + 1; j < N_DIGITS; j++) begin
                if (digits[i*DIGIT_W +: DIGIT_W] == digits[j*DIGIT_W +: DIGIT_W]) valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bulls_cows_game_n.sv
// rtl/bulls_cows_game_n.sv - two-player bulls and cows engine scoring one digit per clock
module bulls_cows_game_n
    import bc_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGIT  = 9,
    parameter int MAX_ROUNDS = 10
) (
    input  logic              clock,
    input  logic              reset,
    bulls_cows_game_n_if.slave bus
);

    localparam int SW_W = N_DIGITS * DIGIT_W;
    localparam int CW   = $clog2(N_DIGITS + 1);
    localparam int RW   = $clog2(MAX_ROUNDS + 1);
    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CW_MAX   = CW'(N_DIGITS);
    localparam logic [RW-1:0] RW_MAX   = RW'(MAX_ROUNDS);
    localparam logic [RW-1:0] RW_LAST  = RW'(MAX_ROUNDS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    state_t                state, state_n, ret_state;
    logic                  cfm_q, cfm_edge;
    logic [SW_W-1:0]       secret1, secret2, guess, entry, target;
    logic                  entry_ok;
    logic                  player, err, winner;
    logic [CW-1:0]         bulls, cows, bacc, cacc, bulls_n, cows_n;
    logic [RW-1:0]         rounds;
    logic [IW-1:0]         idx;
    logic [2*N_DIGITS-1:0] led, led_n;
    logic [DIGIT_W-1:0]    cur_g;
    logic                  is_bull, is_cow;

    assign cfm_edge = bus.confirma & ~cfm_q;
    assign target   = player ? secret1 : secret2;

    always_comb begin
        case (ret_state)
            P1_SETUP: entry = secret1;
            P2_SETUP: entry = secret2;
            default:  entry = guess;
        endcase
    end

    bc_digit_validator #(
        .N_DIGITS (N_DIGITS),
        .DIGIT_W  (DIGIT_W),
        .MAX_DIGIT(MAX_DIGIT)
    ) u_validator (
        .digits(entry),
        .valid (entry_ok)
    );

    // One guess digit per cycle against the whole secret; distinct digits mean at most one hit.
    always_comb begin
        cur_g = DIGIT_W'(DIGIT_NULL);
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) cur_g = guess[i*DIGIT_W +: DIGIT_W];
        end
        is_bull = 1'b0;
        is_cow  = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (cur_g == target[j*DIGIT_W +: DIGIT_W]) begin
                if (idx == IW'(j)) is_bull = 1'b1;
                else               is_cow  = 1'b1;
            end
        end
        bulls_n = bacc;
        cows_n  = cacc;
        if (is_bull && bacc < CW_MAX) bulls_n = bacc + CW'(1);
        if (is_cow  && cacc < CW_MAX) cows_n  = cacc + CW'(1);
        led_n = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            led_n[i]            = (CW'(i) < bulls_n);
            led_n[N_DIGITS + i] = (CW'(i) < cows_n);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            P1_SETUP, P2_SETUP, P1_GUESS, P2_GUESS: if (cfm_edge) state_n = CHECK;
            CHECK: begin
                if (!entry_ok)                 state_n = ret_state;
                else if (ret_state == P1_SETUP) state_n = P2_SETUP;
                else if (ret_state == P2_SETUP) state_n = P1_GUESS;
                else                            state_n = SCORE;
            end
            SCORE: if (idx == IDX_LAST) state_n = RESULT;
            RESULT: begin
                if (cfm_edge) begin
                    if (bulls == CW_MAX)      state_n = WIN;
                    else if (!player)         state_n = P2_GUESS;
                    else if (rounds >= RW_LAST) state_n = DRAW;
                    else                      state_n = P1_GUESS;
                end
            end
            WIN:     if (cfm_edge) state_n = P1_SETUP;
            DRAW:    state_n = DRAW;
            default: state_n = P1_SETUP;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= P1_SETUP;
        else       state <= state_n;
    end

    // cfm_q resets high so a button held through reset needs a release before it counts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfm_q     <= 1'b1;
            secret1   <= '0;
            secret2   <= '0;
            guess     <= '0;
            ret_state <= P1_SETUP;
            player    <= 1'b0;
            err       <= 1'b0;
            winner    <= 1'b0;
            bulls     <= '0;
            cows      <= '0;
            bacc      <= '0;
            cacc      <= '0;
            rounds    <= '0;
            idx       <= '0;
            led       <= '0;
        end else begin
            cfm_q <= bus.confirma;
            case (state)
                P1_SETUP, P2_SETUP, P1_GUESS, P2_GUESS: begin
                    if (cfm_edge) begin
                        case (state)
                            P1_SETUP: secret1 <= bus.SW;
                            P2_SETUP: secret2 <= bus.SW;
                            default:  guess   <= bus.SW;
                        endcase
                        ret_state <= state;
                        err       <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!entry_ok) begin
                        err <= 1'b1;
                    end else begin
                        idx  <= '0;
                        bacc <= '0;
                        cacc <= '0;
                    end
                end
                SCORE: begin
                    bacc <= bulls_n;
                    cacc <= cows_n;
                    if (idx != IDX_LAST) begin
                        idx <= idx + IW'(1);
                    end else begin
                        bulls <= bulls_n;
                        cows  <= cows_n;
                        led   <= led_n;
                    end
                end
                RESULT: begin
                    if (cfm_edge) begin
                        if (bulls == CW_MAX) begin
                            winner <= player;
                        end else if (!player) begin
                            player <= 1'b1;
                        end else begin
                            if (rounds < RW_MAX) rounds <= rounds + RW'(1);
                            if (rounds < RW_LAST) player <= 1'b0;
                        end
                    end
                end
                WIN: begin
                    if (cfm_edge) begin
                        secret1   <= '0;
                        secret2   <= '0;
                        guess     <= '0;
                        ret_state <= P1_SETUP;
                        player    <= 1'b0;
                        err       <= 1'b0;
                        winner    <= 1'b0;
                        bulls     <= '0;
                        cows      <= '0;
                        bacc      <= '0;
                        cacc      <= '0;
                        rounds    <= '0;
                        idx       <= '0;
                        led       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state_o  = state;
    assign bus.player_o = player;
    assign bus.bulls_o  = bulls;
    assign bus.cows_o   = cows;
    assign bus.round_o  = rounds;
    assign bus.err_o    = err;
    assign bus.winner_o = winner;
    assign bus.led_o    = led;

endmodule
